dbus_arbiter: RTL and testbench

//   Two-master arbiter for the shared data bus in front of the address decoder (DMEM 0x1xxx_xxxx, TBMAN 0x8000_Fxxx).
//   M0 = CPU load/store unit, M1 = secondary master (testbench loader / future DMA).

---
 rtl/dbus_pkg.sv | 27 ++
 rtl/dbus_arb_pick.sv | 48 ++++
 rtl/dbus_arbiter.sv | 144 ++++++++++++++
 tb/tb_dbus_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus arbiter.
package dbus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [3:0]  DMEM_BASE  = 4'h1;
  localparam logic [19:0] TBMAN_BASE = 20'h8000F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/dbus_arb_pick.sv
// Winner select for the two masters.
// DBUS_ARB_RR_EN defined: ties alternate (round-robin on the last winner).
// Undefined: fixed priority, M0 wins ties.
module dbus_arb_pick
  import dbus_pkg::*;
(
`ifdef DBUS_ARB_RR_EN
  input  logic clk,
  input  logic reset,
  input  logic grant,
`endif
  input  logic req0,
  input  logic req1,
  output logic winner_c
);

`ifdef DBUS_ARB_RR_EN
  logic last;

  // On a tie the master that did not win last time goes first
  always_comb begin
    winner_c = M0;
    if (req0 && req1) begin
      winner_c = ~last;
    end else if (req1) begin
      winner_c = M1;
    end
  end

  // Track the most recent winner; reset favours M0 on the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= M1;
    end else if (grant) begin
      last <= winner_c;
    end
  end
`else
  // M1 only wins when M0 is not requesting
  always_comb begin
    winner_c = M0;
    if (!req0 && req1) begin
      winner_c = M1;
    end
  end
`endif

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: grant, hold command until slave ready,
// return data/error; unmapped addresses and slave timeouts give err=1.
// Optional macro DBUS_ARB_RR_EN selects round-robin arbitration.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        s_cs_none
);

  state_t            state, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              owner_q, owner_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              any_req_c, winner_c, grant_c;
  cmd_t              m0_cmd_c, m1_cmd_c;

  assign any_req_c = m0_req | m1_req;
  assign grant_c   = (state == IDLE) & any_req_c & ~reset;
  assign m0_cmd_c  = '{addr: m0_addr, we: m0_we, be: m0_be, wdata: m0_wdata};
  assign m1_cmd_c  = '{addr: m1_addr, we: m1_we, be: m1_be, wdata: m1_wdata};

  dbus_arb_pick u_pick (
`ifdef DBUS_ARB_RR_EN
    .clk      (clk),
    .reset    (reset),
    .grant    (grant_c),
`endif
    .req0     (m0_req),
    .req1     (m1_req),
    .winner_c (winner_c)
  );

  // State, command and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cmd_q   <= '0;
      owner_q <= M0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: grant in IDLE, wait for ready/unmapped/timeout in ACCESS
  always_comb begin
    state_d = state;
    cmd_d   = cmd_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state)
      IDLE: begin
        if (any_req_c) begin
          cmd_d   = (winner_c == M1) ? m1_cmd_c : m0_cmd_c;
          owner_d = winner_c;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (s_cs_none) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (s_ready) begin
          rdata_d = cmd_q.we ? '0 : s_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grants are combinational in IDLE; the slave command comes from the latch
  assign m0_gnt  = grant_c & (winner_c == M0);
  assign m1_gnt  = grant_c & (winner_c == M1);
  assign s_valid = (state == ACCESS) & ~s_cs_none;
  assign s_addr  = cmd_q.addr;
  assign s_we    = cmd_q.we;
  assign s_be    = cmd_q.be;
  assign s_wdata = cmd_q.wdata;

  // Response goes only to the owner; the other master sees zeros
  assign m0_rvalid = (state == RESP) & (owner_q == M0);
  assign m1_rvalid = (state == RESP) & (owner_q == M1);
  assign m0_rdata  = m0_rvalid ? rdata_q : '0;
  assign m1_rdata  = m1_rvalid ? rdata_q : '0;
  assign m0_err    = m0_rvalid & err_q;
  assign m1_err    = m1_rvalid & err_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: transaction table plus reset corner cases.
module tb_dbus_arbiter;

  localparam int TO = 16;

`ifdef DBUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        s_valid, s_we, s_ready, s_cs_none;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.TIMEOUT(TO), .TO_W(5)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .s_cs_none(s_cs_none)
  );

  typedef struct {
    logic        req0;
    logic        req1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic        we;
    logic [31:0] wdata;
    logic        cs_none;
    int          wait_n;     // not-ready cycles before s_ready; >= TO means never
    logic [31:0] rdata;
    logic        win;
    logic        err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic r0, logic r1, logic [31:0] a0, logic [31:0] a1,
                              logic we, logic [31:0] wd, logic csn, int wn,
                              logic [31:0] rd, logic win, logic err, logic [31:0] erd);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.addr0 = a0; v.addr1 = a1; v.we = we; v.wdata = wd;
    v.cs_none = csn; v.wait_n = wn; v.rdata = rd; v.win = win; v.err = err;
    v.exp_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d) at %0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  // Full transaction starting #1 after an edge with the DUT in IDLE
  task automatic run_txn(input vec_t v, input int idx);
    logic [31:0] ea, ew;
    int          n_acc;
    ea = v.win ? v.addr1 : v.addr0;
    ew = v.win ? ~v.wdata : v.wdata;
    if (v.cs_none)       n_acc = 1;
    else if (v.wait_n < TO) n_acc = v.wait_n + 1;
    else                 n_acc = TO;

    m0_req = v.req0; m0_addr = v.addr0; m0_we = v.we; m0_wdata = v.wdata;  m0_be = 4'hF;
    m1_req = v.req1; m1_addr = v.addr1; m1_we = v.we; m1_wdata = ~v.wdata; m1_be = 4'hF;
    #1;
    chk("m0_gnt", idx, 32'(m0_gnt), 32'(v.win == 1'b0));
    chk("m1_gnt", idx, 32'(m1_gnt), 32'(v.win == 1'b1));
    @(posedge clk); #1;
    // Winner drops its request and scribbles on its command lines
    if (v.win) begin m1_req = 1'b0; m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'h0; end
    else       begin m0_req = 1'b0; m0_addr = 32'hFFFF_FFFF; m0_wdata = 32'h0; end

    for (int i = 0; i < n_acc; i++) begin
      s_cs_none = v.cs_none;
      s_ready   = !v.cs_none && (i == v.wait_n);
      s_rdata   = v.rdata;
      #1;
      chk("s_valid", idx, 32'(s_valid), 32'(!v.cs_none));
      chk("s_addr", idx, s_addr, ea);
      chk("s_wdata", idx, s_wdata, ew);
      chk("s_we", idx, 32'(s_we), 32'(v.we));
      chk("gnt_in_access", idx, 32'(m0_gnt | m1_gnt), 32'd0);
      chk("early_rvalid", idx, 32'(m0_rvalid | m1_rvalid), 32'd0);
      @(posedge clk); #1;
    end

    s_ready = 1'b0; s_cs_none = 1'b0; s_rdata = 32'h5555_AAAA;
    #1;
    chk("win_rvalid", idx, 32'(v.win ? m1_rvalid : m0_rvalid), 32'd1);
    chk("lose_rvalid", idx, 32'(v.win ? m0_rvalid : m1_rvalid), 32'd0);
    chk("win_rdata", idx, v.win ? m1_rdata : m0_rdata, v.exp_rdata);
    chk("win_err", idx, 32'(v.win ? m1_err : m0_err), 32'(v.err));
    chk("lose_rdata", idx, v.win ? m0_rdata : m1_rdata, 32'd0);
    chk("resp_s_valid", idx, 32'(s_valid), 32'd0);
    @(posedge clk); #1;
    chk("rvalid_one_cycle", idx, 32'(m0_rvalid | m1_rvalid), 32'd0);
  endtask

  initial begin
    vecs[0] = mk(1, 0, 32'h1000_0010, 32'h0, 0, 32'h0, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF);
    vecs[1] = mk(1, 0, 32'h4000_0000, 32'h0, 0, 32'h0, 1, 0, 32'h1111_2222, 0, 1, 32'h0);
    vecs[2] = mk(0, 1, 32'h0, 32'h8000_F000, 1, 32'hFFFF_FFFE, 0, 2, 32'h0000_1234, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      vecs[3+i] = mk(1, 1, 32'h1000_0100, 32'h1000_0200, 0, 32'h0, 0, 0,
                     32'hA5A5_0000 + 32'(i), RR ? 1'(i % 2) : 1'b0, 0, 32'hA5A5_0000 + 32'(i));
    end
    vecs[7] = mk(0, 1, 32'h0, 32'h1000_0300, 0, 32'h0, 0, 99, 32'h7777_7777, 1, 1, 32'h0);
    vecs[8] = mk(1, 0, 32'h1000_0400, 32'h0, 0, 32'h0, 0, TO - 1, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D);
    vecs[9] = mk(1, 0, 32'h1000_0500, 32'h0, 0, 32'h0, 0, 0, 32'h0BAD_CAFE, 0, 0, 32'h0BAD_CAFE);

    // Reset state, with a request already pending
    reset = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h1000_0000; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_addr = 32'h0; m1_we = 1'b0; m1_be = 4'h0; m1_wdata = 32'h0;
    s_ready = 1'b0; s_rdata = 32'h0; s_cs_none = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m0_gnt", -1, 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", -1, 32'(m1_gnt), 32'd0);
    chk("rst_s_valid", -1, 32'(s_valid), 32'd0);
    chk("rst_s_addr", -1, s_addr, 32'd0);
    chk("rst_rvalid", -1, 32'(m0_rvalid | m1_rvalid), 32'd0);
    chk("rst_rdata", -1, m0_rdata | m1_rdata, 32'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(vecs[i], i);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of ACCESS aborts the transfer silently
    m0_req = 1'b1; m0_addr = 32'h1000_0040; m0_we = 1'b0;
    #1;
    chk("ra_gnt", 100, 32'(m0_gnt), 32'd1);
    @(posedge clk); #1;
    m0_req = 1'b0; s_ready = 1'b0;
    #1;
    chk("ra_s_valid", 100, 32'(s_valid), 32'd1);
    chk("ra_s_addr", 100, s_addr, 32'h1000_0040);
    reset = 1'b1; m0_req = 1'b1;
    #1;
    chk("ra_rst_s_valid", 100, 32'(s_valid), 32'd0);
    chk("ra_rst_s_addr", 100, s_addr, 32'd0);
    chk("ra_rst_gnt", 100, 32'(m0_gnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; m0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ra_no_rvalid", 100 + i, 32'(m0_rvalid | m1_rvalid), 32'd0);
      chk("ra_idle_s_valid", 100 + i, 32'(s_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_txn(vecs[9], 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
